fetch_stage: RTL and testbench

Instruction-fetch stage of the multi-cycle MIPS datapath. Holds the program counter, fetches one word per instruction from instruction memory over a req/ack handshake, and presents it to decode with a valid/ready handshake. Produces PC_PLUS4, which drives input A of the downstream PC-source MUX21. Consumes that mux's output O on NEXT_PC whenever control asserts REDIRECT (branch/jump).

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handshake and PC-source mux link.
// master = fetch stage, slave = environment (memory, decode, control).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        fault;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc_out, pc_plus4, fault,
    input  imem_ack, imem_rdata, instr_ready, next_pc, redirect
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc_out, pc_plus4, fault,
    output imem_ack, imem_rdata, instr_ready, next_pc, redirect
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the multi-cycle MIPS datapath: PC register, imem req/ack fetch,
// valid/ready hand-off to decode, redirect from the PC-source mux, sticky fault.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_START   | one cycle after reset, no request
// ST_FETCH   | imem_req high at PC, waiting for imem_ack (bounded by WAIT_LIMIT)
// ST_HOLD    | instr/pc_out presented to decode until instr_ready
// ST_FAULTED | timeout or misaligned redirect; only reset leaves
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic         clk,
  input logic         rst_n,
  fetch_stage_if.master bus
);
  localparam logic [1:0] ST_START   = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_FAULTED = 2'd3;

  localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic [7:0]  wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_START;
      pc       <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= RESET_PC;
      wait_cnt <= '0;
    end else if (state != ST_FAULTED && bus.redirect) begin
      // Redirect wins over a same-cycle ack or ready; a misaligned target leaves PC intact.
      if (bus.next_pc[1:0] != 2'b00) begin
        state <= ST_FAULTED;
      end else begin
        pc       <= bus.next_pc;
        state    <= ST_FETCH;
        wait_cnt <= '0;
      end
    end else begin
      case (state)
        ST_START: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            instr_q  <= bus.imem_rdata;
            pc_out_q <= pc;
            pc       <= pc + 32'd4;
            state    <= ST_HOLD;
          end else if (wait_cnt == WAIT_LIMIT_C) begin
            state <= ST_FAULTED;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (bus.instr_ready) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
          end
        end
        default: state <= ST_FAULTED;
      endcase
    end
  end

  assign bus.imem_req    = (state == ST_FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state == ST_HOLD);
  assign bus.pc_out      = pc_out_q;
  assign bus.pc_plus4    = pc_out_q + 32'd4;
  assign bus.fault       = (state == ST_FAULTED);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a behavioural reference model.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0400;
  localparam int          WLIM   = 15;

  logic clk;
  logic rst_n;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC), .WAIT_LIMIT(WLIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: what has been fetched, what is on offer, how long we have waited
  logic [31:0] m_pc, m_instr, m_pc_out;
  bit          m_boot, m_have, m_fault;
  int          m_spent;

  task automatic model_reset();
    m_pc = RST_PC; m_instr = '0; m_pc_out = RST_PC;
    m_boot = 1'b1; m_have = 1'b0; m_fault = 1'b0; m_spent = 0;
  endtask

  task automatic model_edge();
    if (m_fault) return;
    if (bus.redirect) begin
      if (bus.next_pc % 4 != 0) begin
        m_fault = 1'b1; m_have = 1'b0;
      end else begin
        m_pc = bus.next_pc; m_have = 1'b0; m_boot = 1'b0; m_spent = 0;
      end
    end else if (m_boot) begin
      m_boot = 1'b0; m_spent = 0;
    end else if (m_have) begin
      if (bus.instr_ready) begin m_have = 1'b0; m_spent = 0; end
    end else begin
      m_spent++;
      if (bus.imem_ack) begin
        m_instr = bus.imem_rdata; m_pc_out = m_pc; m_pc = m_pc + 32'd4; m_have = 1'b1;
      end else if (m_spent > WLIM) begin
        m_fault = 1'b1;
      end
    end
  endtask

  function automatic bit m_fetching();
    return !m_boot && !m_have && !m_fault;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".req"},   32'(bus.imem_req),    32'(m_fetching()));
    check({tag, ".addr"},  bus.imem_addr,        m_pc);
    check({tag, ".valid"}, 32'(bus.instr_valid), 32'(m_have && !m_fault));
    check({tag, ".instr"}, bus.instr,            m_instr);
    check({tag, ".pcout"}, bus.pc_out,           m_pc_out);
    check({tag, ".pcp4"},  bus.pc_plus4,         m_pc_out + 32'd4);
    check({tag, ".fault"}, 32'(bus.fault),       32'(m_fault));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    cycle("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic until_fetching(input string tag);
    for (int i = 0; i < 40 && !m_fetching(); i++) cycle(tag);
    check({tag, ".reached_fetch"}, 32'(m_fetching()), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2008_0005; bus.instr_ready = 1'b1;
    bus.next_pc = '0; bus.redirect = 1'b0;
    #1;
    do_reset();

    // boot with zero-wait memory: 0x400, 0x404, 0x408
    for (int i = 0; i < 5; i++) cycle("boot");
    check("boot.addr408", bus.imem_addr, 32'h408);
    check("boot.pcout404", bus.pc_out, 32'h404);

    // redirect with a concurrent ack: ack discarded
    bus.redirect = 1'b1; bus.next_pc = 32'h1000;
    cycle("redir");
    check("redir.addr", bus.imem_addr, 32'h1000);
    check("redir.pcout_kept", bus.pc_out, 32'h404);
    bus.redirect = 1'b0;

    // backpressure in HOLD
    bus.instr_ready = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      cycle("bp");
      bus.imem_rdata = $urandom();
    end
    check("bp.pcout", bus.pc_out, 32'h1000);
    bus.instr_ready = 1'b1;
    cycle("bp_release");
    check("bp.next_addr", bus.imem_addr, 32'h1004);

    // randomized traffic, aligned redirects only
    for (int i = 0; i < 400; i++) begin
      bus.imem_ack    = ($urandom_range(9) < 7);
      bus.imem_rdata  = $urandom();
      bus.instr_ready = ($urandom_range(3) != 0);
      bus.redirect    = ($urandom_range(19) == 0);
      bus.next_pc     = $urandom() & 32'hFFFF_FFFC;
      cycle("rand");
    end
    bus.redirect = 1'b0; bus.imem_ack = 1'b1;

    // misaligned redirect faults, sticky
    until_fetching("mis");
    bus.redirect = 1'b1; bus.next_pc = 32'h1002;
    cycle("mis");
    check("mis.fault", 32'(bus.fault), 32'd1);
    check("mis.req", 32'(bus.imem_req), 32'd0);
    bus.next_pc = 32'h2000;
    for (int i = 0; i < 3; i++) cycle("mis_sticky");
    bus.redirect = 1'b0;

    // ack in the 16th FETCH cycle is still accepted
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    do_reset();
    cycle("to_boot");
    for (int i = 0; i < WLIM; i++) cycle("to_wait");
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    cycle("to_accept");
    check("to_accept.valid", 32'(bus.instr_valid), 32'd1);
    check("to_accept.fault", 32'(bus.fault), 32'd0);

    // no ack for 16 FETCH cycles -> fault, sticky
    bus.imem_ack = 1'b0;
    do_reset();
    cycle("tf_boot");
    for (int i = 0; i < WLIM + 1; i++) cycle("tf_wait");
    check("tf.fault", 32'(bus.fault), 32'd1);
    bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.next_pc = 32'h3000;
    for (int i = 0; i < 3; i++) cycle("tf_sticky");
    bus.redirect = 1'b0;

    // PC wrap
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    do_reset();
    bus.redirect = 1'b1; bus.next_pc = 32'hFFFF_FFFC;
    cycle("wrap_redir");
    bus.redirect = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = $urandom();
    cycle("wrap_fetch");
    check("wrap.pcp4", bus.pc_plus4, 32'h0);
    check("wrap.addr", bus.imem_addr, 32'h0);
    check("wrap.fault", 32'(bus.fault), 32'd0);

    // asynchronous reset in the middle of a FETCH
    bus.instr_ready = 1'b1; bus.imem_ack = 1'b0;
    until_fetching("mid");
    do_reset();
    check("mid.addr", bus.imem_addr, 32'h0000_0404 + 32'hFFFF_FFFC);
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) cycle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
